// File: rtl/sha256_pkg.sv
// Shared widths and output-register state encoding for the SHA-256 ID validator.
package sha256_pkg;
  localparam int unsigned ID_WIDTH   = 6;
  localparam int unsigned HASH_WIDTH = 256;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/sha256_id_validator_if.sv
// Handshake bundle between the ID issuer / SHA-256 core (master) and the validator (slave).
interface sha256_id_validator_if;
  import sha256_pkg::*;

  logic [ID_WIDTH-1:0]   id_in;
  logic                  id_in_last;
  logic                  id_in_valid;
  logic                  id_in_ready;

  logic [HASH_WIDTH-1:0] hash_in;
  logic [ID_WIDTH-1:0]   hash_in_id;
  logic                  hash_in_last;
  logic                  hash_in_valid;
  logic                  hash_in_ready;

  logic [HASH_WIDTH-1:0] hash_out;
  logic                  hash_out_last;
  logic                  hash_out_err;
  logic                  hash_out_valid;
  logic                  hash_out_ready;

  modport master (
    output id_in, id_in_last, id_in_valid,
    input  id_in_ready,
    output hash_in, hash_in_id, hash_in_last, hash_in_valid,
    input  hash_in_ready,
    input  hash_out, hash_out_last, hash_out_err, hash_out_valid,
    output hash_out_ready
  );

  modport slave (
    input  id_in, id_in_last, id_in_valid,
    output id_in_ready,
    input  hash_in, hash_in_id, hash_in_last, hash_in_valid,
    output hash_in_ready,
    output hash_out, hash_out_last, hash_out_err, hash_out_valid,
    input  hash_out_ready
  );
endinterface

// File: rtl/sha256_id_fifo.sv
// Expected-ID FIFO with extra-MSB pointers; head is registered storage, no push-to-head bypass.
module sha256_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/sha256_id_validator.sv
// Checks each SHA-256 digest's packet ID against the next expected ID and registers the
// digest with an error flag; keeps a saturating mismatch count and a sticky error bit.
module sha256_id_validator
  import sha256_pkg::*;
#(
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  en,
  sha256_id_validator_if.slave  bus,
  output logic [7:0]            err_count,
  output logic                  err_sticky
);
  out_state_e            state_q, state_d;
  logic [HASH_WIDTH-1:0] hash_q, hash_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  sticky_q, sticky_d;

  logic                  fifo_full, fifo_empty;
  logic [ID_WIDTH-1:0]   fifo_head;
  logic                  id_fire, hash_fire, out_fire, mismatch;
  logic                  id_last_unused;

  // The issuer always drives last=1 on IDs; nothing depends on it.
  assign id_last_unused = bus.id_in_last;

  assign bus.id_in_ready   = en && !fifo_full && !sync_rst;
  assign bus.hash_in_ready = en && !fifo_empty && !sync_rst &&
                             ((state_q == OUT_EMPTY) || bus.hash_out_ready);

  assign id_fire   = bus.id_in_valid && bus.id_in_ready;
  assign hash_fire = bus.hash_in_valid && bus.hash_in_ready;
  assign out_fire  = (state_q == OUT_FULL) && bus.hash_out_ready;
  assign mismatch  = (bus.hash_in_id != fifo_head);

  sha256_id_fifo #(
    .DEPTH (ID_FIFO_DEPTH),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .push     (id_fire),
    .pop      (hash_fire),
    .din      (bus.id_in),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    hash_d   = hash_q;
    last_d   = last_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    unique case (state_q)
      OUT_EMPTY: if (hash_fire) state_d = OUT_FULL;
      OUT_FULL:  if (out_fire && !hash_fire) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
    if (hash_fire) begin
      hash_d = bus.hash_in;
      last_d = bus.hash_in_last;
      err_d  = mismatch;
      if (mismatch) begin
        sticky_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q  <= OUT_EMPTY;
      hash_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hash_q   <= hash_d;
      last_q   <= last_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.hash_out       = hash_q;
  assign bus.hash_out_last  = last_q;
  assign bus.hash_out_err   = err_q;
  assign bus.hash_out_valid = (state_q == OUT_FULL);
  assign err_count          = cnt_q;
  assign err_sticky         = sticky_q;
endmodule

// File: tb/tb_sha256_id_validator.sv
// Directed, table-driven bench for sha256_id_validator with hand-written multi-cycle sequences.
module tb_sha256_id_validator;
  logic       clk = 1'b0;
  logic       sync_rst;
  logic       en;
  logic [7:0] err_count;
  logic       err_sticky;

  int unsigned tests = 0;
  int unsigned fails = 0;

  sha256_id_validator_if bus ();

  sha256_id_validator #(.ID_FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .en         (en),
    .bus        (bus),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] push_id;
    logic [5:0] hash_id;
    logic       last;
    logic       exp_err;
    logic [7:0] exp_cnt;
    logic       exp_sticky;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [255:0] dig(input int unsigned k);
    logic [255:0] r;
    for (int unsigned j = 0; j < 8; j++)
      r[j*32 +: 32] = 32'hA5000000 ^ (k * 32'h9E3779B1) ^ j;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [5:0] id);
    bit done = 1'b0;
    bus.id_in = id;
    bus.id_in_last = 1'b1;
    bus.id_in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.id_in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.id_in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: id_in_ready never high for id %0d", id);
    end
  endtask

  task automatic send_hash(input logic [5:0] id, input logic [255:0] d, input logic last);
    bit done = 1'b0;
    bus.hash_in = d;
    bus.hash_in_id = id;
    bus.hash_in_last = last;
    bus.hash_in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.hash_in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.hash_in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL hash_timeout: hash_in_ready never high for id %0d", id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_cnt;

    vecs[0] = '{push_id: 6'd5,  hash_id: 6'd7,  last: 1'b1, exp_err: 1'b1, exp_cnt: 8'd1, exp_sticky: 1'b1};
    vecs[1] = '{push_id: 6'd9,  hash_id: 6'd9,  last: 1'b0, exp_err: 1'b0, exp_cnt: 8'd1, exp_sticky: 1'b1};
    vecs[2] = '{push_id: 6'd62, hash_id: 6'd62, last: 1'b1, exp_err: 1'b0, exp_cnt: 8'd1, exp_sticky: 1'b1};
    vecs[3] = '{push_id: 6'd63, hash_id: 6'd63, last: 1'b0, exp_err: 1'b0, exp_cnt: 8'd1, exp_sticky: 1'b1};
    vecs[4] = '{push_id: 6'd0,  hash_id: 6'd0,  last: 1'b1, exp_err: 1'b0, exp_cnt: 8'd1, exp_sticky: 1'b1};
    vecs[5] = '{push_id: 6'd1,  hash_id: 6'd1,  last: 1'b1, exp_err: 1'b0, exp_cnt: 8'd1, exp_sticky: 1'b1};

    sync_rst = 1'b1;
    en = 1'b1;
    bus.id_in = '0;
    bus.id_in_last = 1'b1;
    bus.id_in_valid = 1'b0;
    bus.hash_in = '0;
    bus.hash_in_id = '0;
    bus.hash_in_last = 1'b0;
    bus.hash_in_valid = 1'b0;
    bus.hash_out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_id_ready", bus.id_in_ready, 1'b0);
    chk("rst_hash_ready", bus.hash_in_ready, 1'b0);
    chk("rst_out_valid", bus.hash_out_valid, 1'b0);
    chk("rst_hash_out", bus.hash_out, '0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_err_sticky", err_sticky, 1'b0);
    sync_rst = 1'b0;
    #1;
    chk("idle_id_ready", bus.id_in_ready, 1'b1);
    chk("idle_hash_ready_empty", bus.hash_in_ready, 1'b0);

    // Three matched digests back to back
    push_id(6'd0);
    push_id(6'd1);
    push_id(6'd2);
    chk("seq_out_valid_pre", bus.hash_out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.hash_in = dig(i);
      bus.hash_in_id = 6'(i);
      bus.hash_in_last = (i == 2);
      bus.hash_in_valid = 1'b1;
      #1;
      chk("seq_hash_ready", bus.hash_in_ready, 1'b1);
      step();
      chk("seq_out_valid", bus.hash_out_valid, 1'b1);
      chk("seq_hash_out", bus.hash_out, dig(i));
      chk("seq_out_last", bus.hash_out_last, (i == 2));
      chk("seq_out_err", bus.hash_out_err, 1'b0);
    end
    bus.hash_in_valid = 1'b0;
    step();
    chk("seq_drained", bus.hash_out_valid, 1'b0);
    chk("seq_err_count", err_count, 8'd0);

    // Table: mismatch then matched pairs including 63 -> 0 wrap
    for (int i = 0; i < 6; i++) begin
      push_id(vecs[i].push_id);
      send_hash(vecs[i].hash_id, dig(100 + i), vecs[i].last);
      chk("vec_out_valid", bus.hash_out_valid, 1'b1);
      chk("vec_hash_out", bus.hash_out, dig(100 + i));
      chk("vec_out_last", bus.hash_out_last, vecs[i].last);
      chk("vec_out_err", bus.hash_out_err, vecs[i].exp_err);
      chk("vec_err_count", err_count, vecs[i].exp_cnt);
      chk("vec_err_sticky", err_sticky, vecs[i].exp_sticky);
      step();
    end

    // 256 forced mismatches, count saturates at 255
    exp_cnt = 8'd1;
    for (int i = 0; i < 256; i++) begin
      push_id(6'(i));
      send_hash(~6'(i), dig(i), 1'b1);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk("sat_out_err", bus.hash_out_err, 1'b1);
      chk("sat_err_count", err_count, exp_cnt);
    end
    step();
    chk("sat_final", err_count, 8'd255);

    // Fill FIFO, fifth push refused, one pop frees a slot
    push_id(6'd10);
    push_id(6'd11);
    push_id(6'd12);
    push_id(6'd13);
    bus.id_in = 6'd14;
    bus.id_in_valid = 1'b1;
    #1;
    chk("full_id_ready", bus.id_in_ready, 1'b0);
    bus.id_in_valid = 1'b0;
    send_hash(6'd10, dig(10), 1'b0);
    chk("full_pop_id_ready", bus.id_in_ready, 1'b1);
    chk("full_pop_err", bus.hash_out_err, 1'b0);
    chk("full_pop_hash", bus.hash_out, dig(10));

    // Backpressure: output held stable for 5 cycles, then drain + accept together
    bus.hash_out_ready = 1'b0;
    bus.hash_in = dig(11);
    bus.hash_in_id = 6'd11;
    bus.hash_in_last = 1'b1;
    bus.hash_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hash_ready", bus.hash_in_ready, 1'b0);
      chk("bp_hash_stable", bus.hash_out, dig(10));
      chk("bp_valid_stable", bus.hash_out_valid, 1'b1);
      chk("bp_last_stable", bus.hash_out_last, 1'b0);
      step();
    end
    bus.hash_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.hash_in_ready, 1'b1);
    step();
    bus.hash_in_valid = 1'b0;
    bus.hash_out_ready = 1'b0;
    chk("bp_next_valid", bus.hash_out_valid, 1'b1);
    chk("bp_next_hash", bus.hash_out, dig(11));
    chk("bp_next_last", bus.hash_out_last, 1'b1);

    // Reset with 3 IDs queued and output FULL
    push_id(6'd20);
    chk("prerst_valid", bus.hash_out_valid, 1'b1);
    sync_rst = 1'b1;
    bus.id_in = 6'd21;
    bus.id_in_valid = 1'b1;
    bus.hash_in = dig(12);
    bus.hash_in_id = 6'd12;
    bus.hash_in_valid = 1'b1;
    bus.hash_out_ready = 1'b1;
    #1;
    chk("midrst_id_ready", bus.id_in_ready, 1'b0);
    chk("midrst_hash_ready", bus.hash_in_ready, 1'b0);
    step();
    chk("postrst_valid", bus.hash_out_valid, 1'b0);
    chk("postrst_hash", bus.hash_out, '0);
    chk("postrst_last", bus.hash_out_last, 1'b0);
    chk("postrst_err", bus.hash_out_err, 1'b0);
    chk("postrst_count", err_count, 8'd0);
    chk("postrst_sticky", err_sticky, 1'b0);
    sync_rst = 1'b0;
    bus.id_in_valid = 1'b0;
    #1;
    chk("postrst_fifo_empty", bus.hash_in_ready, 1'b0);
    step();
    chk("postrst_still_empty", bus.hash_in_ready, 1'b0);
    chk("postrst_no_output", bus.hash_out_valid, 1'b0);
    bus.hash_in_valid = 1'b0;
    bus.hash_out_ready = 1'b0;
    push_id(6'd30);
    #1;
    chk("newid_hash_ready", bus.hash_in_ready, 1'b1);
    send_hash(6'd30, dig(30), 1'b1);
    chk("newid_valid", bus.hash_out_valid, 1'b1);
    chk("newid_err", bus.hash_out_err, 1'b0);
    chk("newid_count", err_count, 8'd0);

    // en low blocks inputs but a pending output still drains
    en = 1'b0;
    bus.id_in = 6'd40;
    bus.id_in_valid = 1'b1;
    #1;
    chk("en_low_id_ready", bus.id_in_ready, 1'b0);
    bus.hash_out_ready = 1'b1;
    step();
    chk("en_low_drained", bus.hash_out_valid, 1'b0);
    bus.id_in_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("en_low_no_push", bus.hash_in_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_id_validator.md
SHA256_ID_VALIDATOR -- requirements
Module: sha256_id_validator

Interface
REQ-001 Parameter: ID_FIFO_DEPTH, 4, number of outstanding packet IDs held; SHALL be a power of two, 2 or greater.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 sync_rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  enable; low SHALL block input handshakes.
REQ-005 id_in  input  6  expected packet ID from the ID issuer buffer port.
REQ-006 id_in_last  input  1  ID last flag; always 1 from the issuer; SHALL be accepted and discarded.
REQ-007 id_in_valid / id_in_ready  input / output  1 / 1  ID handshake.
REQ-008 hash_in  input  256  digest from the SHA-256 core.
REQ-009 hash_in_id  input  6  packet ID carried with the digest.
REQ-010 hash_in_last  input  1  digest last flag.
REQ-011 hash_in_valid / hash_in_ready  input / output  1 / 1  digest handshake.
REQ-012 hash_out, hash_out_last  output  256, 1  registered digest and last flag.
REQ-013 hash_out_err  output  1  high when the digest ID does not match the expected ID.
REQ-014 hash_out_valid / hash_out_ready  output / input  1 / 1  output handshake.
REQ-015 err_count  output  8  saturating count of mismatched digests.
REQ-016 err_sticky  output  1  set on the first mismatch; cleared only by reset.

Function
REQ-017 A transfer SHALL occur on any interface only in a cycle where valid and ready are both high at the clk edge.
REQ-018 id_in_ready SHALL be en AND (FIFO not full), combinational.
REQ-019 An id_in handshake SHALL write id_in to the FIFO tail; occupancy increments by 1.
REQ-020 The FIFO SHALL have no bypass: an ID pushed into an empty FIFO becomes the head one cycle after the push.
REQ-021 hash_in_ready SHALL be en AND (FIFO not empty) AND (output register EMPTY, or output register FULL with hash_out_ready high).
REQ-022 An input digest handshake SHALL pop the FIFO head. In the same edge it SHALL load hash_out, hash_out_last and hash_out_err (= hash_in_id != head), and set hash_out_valid.
REQ-023 Latency from digest input handshake to hash_out_valid SHALL be exactly 1 cycle; throughput SHALL be 1 digest per cycle.
REQ-024 Output register FSM states: EMPTY and FULL. EMPTY goes to FULL on an input digest handshake. FULL goes to EMPTY on an output handshake with no input digest handshake. FULL stays FULL on a simultaneous output and input handshake.
REQ-025 While FULL without an output handshake, hash_out, hash_out_last, hash_out_err and hash_out_valid SHALL hold stable.
REQ-026 en low SHALL NOT affect the output register; a pending output handshake SHALL still complete.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; when full, a pop frees a slot visible as id_in_ready the next cycle.
REQ-028 Pointers SHALL be log2(ID_FIFO_DEPTH)+1 bits. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal. Pointers SHALL wrap modulo 2*ID_FIFO_DEPTH.
REQ-029 ID comparison SHALL use the full 6 bits; ID 63 followed by ID 0 is valid wrap-around and SHALL NOT be flagged.
REQ-030 err_count SHALL increment on each input digest handshake with a mismatch and saturate at 255. err_sticky SHALL set in the same cycle as the first mismatch.

Reset
REQ-031 A sync_rst high at a clk edge SHALL clear the pointers, occupancy and FSM (state EMPTY). It SHALL also drive hash_out, hash_out_last, hash_out_err, hash_out_valid, err_count and err_sticky to 0.
REQ-032 Reset mid-operation SHALL discard the FIFO contents and any pending output without completing its handshake; reset SHALL take priority over en and all handshakes.
REQ-033 Ready outputs SHALL be 0 in every cycle where sync_rst is high.

Structure
REQ-034 ID_WIDTH=6, HASH_WIDTH=256 and the output FSM state enum SHALL live in the shared package sha256_pkg.
REQ-035 The ID FIFO SHALL be a sub-module sha256_id_fifo (parameters: depth and width; ports: push, pop, full, empty, head).

Verification
REQ-036 Push IDs 0,1,2, then digests with IDs 0,1,2 and hash_out_ready=1: three outputs on consecutive cycles, each 1 cycle after its input, err=0, err_count=0.
REQ-037 Push ID 5, then digest ID 7: hash_out_err=1, err_count=1, err_sticky=1; a following matched pair gives err=0 with err_sticky still 1.
REQ-038 Push 4 IDs with no digests: id_in_ready=0 on the 5th attempt. One digest popped with hash_out_ready=1: id_in_ready=1 the next cycle.
REQ-039 hash_out_ready=0 for 5 cycles while FULL: hash_out stable and hash_in_ready=0; on release, the output drains and the next digest is accepted in the same cycle.
REQ-040 Issue IDs 62,63,0,1 matched with digests: no errors. Then 256 forced mismatches: err_count saturates at 255.
REQ-041 Assert sync_rst with 3 IDs queued and the output FULL: the next cycle has all outputs 0 and the FIFO empty, and hash_in_ready=0 until a new ID is pushed.
